inst_fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the IF/ID boundary. Generates the PC and drives the

---
 rtl/inst_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC generation, instruction ROM fetch, prefetch queue and the
// registered {pc, inst, valid} handoff to decode, with stall and branch redirect.
// Optional feature macro: DELAY_SLOT_EN keeps the delay-slot instruction on redirect;
// with it undefined a redirect flushes everything younger than decode.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);
    localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    // Stage p0: next fetch address
    logic [31:0]      pc_p0;
    // Stage p1: request issued last cycle, its word is on rom_data_i now
    logic             vld_p1;
    logic [31:0]      pc_p1;

    logic [31:0]      q_pc   [DEPTH];
    logic [31:0]      q_inst [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [CNT_W:0]   occ;
    logic             issue;
    logic             q_empty;
    logic             pop;
    logic             bypass;
    logic             push;
    logic [31:0]      head_pc;
    logic [31:0]      head_inst;
    logic [31:0]      target_p0;
    logic [1:0]       unused_target_bits;

    logic             q_wr_en;
    logic [PTR_W-1:0] q_wr_idx;
    logic [31:0]      q_wr_pc;
    logic [31:0]      q_wr_inst;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Queued entries plus the outstanding request must never exceed DEPTH,
    // so every issued request always has a slot waiting for its word.
    assign occ        = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
    assign issue      = ~rst & (occ < DEPTH_C);
    assign rom_ce_o   = issue;
    assign rom_addr_o = rst ? 32'h0 : pc_p0;

    assign q_empty   = (count == '0);
    assign head_pc   = q_pc[rd_ptr];
    assign head_inst = q_inst[rd_ptr];
    // Oldest first: queue head, else the word arriving this cycle.
    assign pop       = ~stall_i & ~q_empty;
    assign bypass    = ~stall_i & q_empty & vld_p1;
    assign push      = vld_p1 & ~bypass;

    assign target_p0          = {branch_target_i[31:2], 2'b00};
    assign unused_target_bits = branch_target_i[1:0];

`ifdef DELAY_SLOT_EN
    logic        slot_vld;
    logic [31:0] slot_pc;
    logic [31:0] slot_inst;
    assign slot_vld  = ~q_empty | vld_p1;
    assign slot_pc   = q_empty ? pc_p1 : head_pc;
    assign slot_inst = q_empty ? rom_data_i : head_inst;
`endif

    // Select what (if anything) is written into the queue this cycle.
    always_comb begin
        q_wr_en   = push & ~branch_flag_i & ~rst;
        q_wr_idx  = wr_ptr;
        q_wr_pc   = pc_p1;
        q_wr_inst = rom_data_i;
`ifdef DELAY_SLOT_EN
        if (~rst & branch_flag_i & stall_i & slot_vld) begin
            q_wr_en   = 1'b1;
            q_wr_idx  = '0;
            q_wr_pc   = slot_pc;
            q_wr_inst = slot_inst;
        end
`endif
    end

    // Queue storage and PC tag of the outstanding request.
    always_ff @(posedge clk) begin
        if (q_wr_en) begin
            q_pc[q_wr_idx]   <= q_wr_pc;
            q_inst[q_wr_idx] <= q_wr_inst;
        end
        if (issue) pc_p1 <= pc_p0;
    end

    // PC, outstanding-request flag and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0  <= RESET_PC;
            vld_p1 <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_flag_i) begin
            pc_p0  <= target_p0;
            vld_p1 <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
`ifdef DELAY_SLOT_EN
            if (stall_i && slot_vld) begin
                wr_ptr <= ptr_inc('0);
                count  <= CNT_W'(1);
            end
`endif
        end else begin
            if (issue) pc_p0 <= pc_p0 + 32'd4;
            vld_p1 <= issue;
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Registered handoff to decode: hold on stall, bubble when nothing is ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_o    <= 32'h0;
            id_inst_o  <= 32'h0;
            id_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (branch_flag_i) begin
`ifdef DELAY_SLOT_EN
                if (slot_vld) begin
                    id_pc_o    <= slot_pc;
                    id_inst_o  <= slot_inst;
                    id_valid_o <= 1'b1;
                end else begin
                    id_inst_o  <= 32'h0;
                    id_valid_o <= 1'b0;
                end
`else
                id_inst_o  <= 32'h0;
                id_valid_o <= 1'b0;
`endif
            end else if (pop) begin
                id_pc_o    <= head_pc;
                id_inst_o  <= head_inst;
                id_valid_o <= 1'b1;
            end else if (bypass) begin
                id_pc_o    <= pc_p1;
                id_inst_o  <= rom_data_i;
                id_valid_o <= 1'b1;
            end else begin
                id_inst_o  <= 32'h0;
                id_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit (default build, DELAY_SLOT_EN undefined).
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    = 1'b1;
    logic        stall  = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] target = 32'h0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    logic        rst2    = 1'b1;
    logic        stall2  = 1'b0;
    logic        branch2 = 1'b0;
    logic [31:0] target2 = 32'h0;
    logic        rom2_ce;
    logic [31:0] rom2_addr;
    logic [31:0] rom2_data = 32'h0;
    logic [31:0] id2_pc;
    logic [31:0] id2_inst;
    logic        id2_valid;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h3401_0000 + (a >> 2);
    endfunction

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr),
        .rom_data_i(rom_data), .stall_i(stall), .branch_flag_i(branch),
        .branch_target_i(target), .id_pc_o(id_pc), .id_inst_o(id_inst),
        .id_valid_o(id_valid)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst2), .rom_ce_o(rom2_ce), .rom_addr_o(rom2_addr),
        .rom_data_i(rom2_data), .stall_i(stall2), .branch_flag_i(branch2),
        .branch_target_i(target2), .id_pc_o(id2_pc), .id_inst_o(id2_inst),
        .id_valid_o(id2_valid)
    );

    // Synchronous ROMs: word valid the cycle after the address; garbage when idle.
    always @(posedge clk) rom_data  <= rom_ce  ? rom_word(rom_addr)  : $urandom;
    always @(posedge clk) rom2_data <= rom2_ce ? rom_word(rom2_addr) : $urandom;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for n edges, release it and settle into cycle 0.
    task automatic do_reset(input int n);
        rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0;
        repeat (n) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (rom_ce !== 1'b0 || rom_addr !== 32'h0) begin
                errors++;
                $display("FAIL reset_rom: got ce=%b addr=%h, expected ce=0 addr=0", rom_ce, rom_addr);
            end
            checks++;
            if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
                errors++;
                $display("FAIL reset_id: got v=%b pc=%h inst=%h, expected all 0", id_valid, id_pc, id_inst);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_fetch: got ce=%b addr=%h, expected ce=1 addr=0", rom_ce, rom_addr);
        end
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL cycle1_bubble: got v=%b, expected 0", id_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_inst !== rom_word(32'(4 * i))) begin
                errors++;
                $display("FAIL reset_stream[%0d]: got v=%b pc=%h inst=%h, expected v=1 pc=%h inst=%h",
                         i, id_valid, id_pc, id_inst, 32'(4 * i), rom_word(32'(4 * i)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(2);
        repeat (4) tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_inst !== rom_word(32'h8)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h, expected v=1 pc=8 inst=%h",
                         i, id_valid, id_pc, id_inst, rom_word(32'h8));
            end
            checks++;
            if (rom_ce !== 1'b0) begin
                errors++;
                $display("FAIL stall_issue_stop[%0d]: got ce=%b, expected 0", i, rom_ce);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(12 + 4 * i) || id_inst !== rom_word(32'(12 + 4 * i))) begin
                errors++;
                $display("FAIL stall_release[%0d]: got v=%b pc=%h inst=%h, expected v=1 pc=%h",
                         i, id_valid, id_pc, id_inst, 32'(12 + 4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(2);
        repeat (4) tick();
        branch = 1'b1; target = 32'h20;
        tick();
        branch = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h8) begin
            errors++;
            $display("FAIL redirect_flush: got v=%b pc=%h inst=%h, expected v=0 pc=8 inst=0", id_valid, id_pc, id_inst);
        end
        checks++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h20) begin
            errors++;
            $display("FAIL redirect_fetch: got ce=%b addr=%h, expected ce=1 addr=20", rom_ce, rom_addr);
        end
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_gap: got v=%b pc=%h, expected v=0", id_valid, id_pc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(32 + 4 * i) || id_inst !== rom_word(32'(32 + 4 * i))) begin
                errors++;
                $display("FAIL redirect_stream[%0d]: got v=%b pc=%h inst=%h, expected v=1 pc=%h",
                         i, id_valid, id_pc, id_inst, 32'(32 + 4 * i));
            end
        end
    endtask

    task automatic test_unaligned_branch_stall();
        logic found;
        do_reset(2);
        repeat (4) tick();
        branch = 1'b1; target = 32'h23; stall = 1'b1;
        tick();
        branch = 1'b0;
        checks++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h20) begin
            errors++;
            $display("FAIL unaligned_fetch: got ce=%b addr=%h, expected ce=1 addr=20", rom_ce, rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h8) begin
                errors++;
                $display("FAIL branch_stall_hold[%0d]: got v=%b pc=%h, expected v=1 pc=8", i, id_valid, id_pc);
            end
            if (i < 2) tick();
        end
        stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick();
            if (id_valid === 1'b1) begin
                found = 1'b1;
                checks++;
                if (id_pc !== 32'h20 || id_inst !== rom_word(32'h20)) begin
                    errors++;
                    $display("FAIL branch_stall_next: got pc=%h inst=%h, expected pc=20 inst=%h",
                             id_pc, id_inst, rom_word(32'h20));
                end
            end
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL branch_stall_timeout: got no valid output, expected pc=20 within 6 cycles");
        end
    endtask

    task automatic test_reset_midstall();
        do_reset(2);
        repeat (4) tick();
        stall = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (rom_ce !== 1'b0 || rom_addr !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
            errors++;
            $display("FAIL midstall_reset: got ce=%b addr=%h v=%b pc=%h inst=%h, expected all 0",
                     rom_ce, rom_addr, id_valid, id_pc, id_inst);
        end
        rst = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin
            errors++;
            $display("FAIL midstall_restart_fetch: got ce=%b addr=%h, expected ce=1 addr=0", rom_ce, rom_addr);
        end
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL midstall_stale: got v=%b pc=%h inst=%h, expected v=0", id_valid, id_pc, id_inst);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_inst !== rom_word(32'(4 * i))) begin
                errors++;
                $display("FAIL midstall_restart[%0d]: got v=%b pc=%h inst=%h, expected v=1 pc=%h",
                         i, id_valid, id_pc, id_inst, 32'(4 * i));
            end
        end
    endtask

    // Random stall/branch/reset against a program-order stream model: every
    // delivery is the next address in program order, a redirect restarts the
    // order at the aligned target, and the only bubbles are the first unstalled
    // delivery right after a reset or redirect.
    task automatic test_random();
        logic        mv, blk, r, s, b;
        logic [31:0] mp, mi, ep, t;
        do_reset(3);
        mv = 1'b0; mp = 32'h0; mi = 32'h0; ep = 32'h0; blk = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 8);
            t = 32'($urandom_range(0, 255));
            rst = r; stall = s; branch = b; target = t;
            tick();
            if (r) begin
                mv = 1'b0; mp = 32'h0; mi = 32'h0; ep = 32'h0; blk = 1'b1;
            end else begin
                if (!s) begin
                    if (b || blk) begin
                        mv = 1'b0; mi = 32'h0;
                    end else begin
                        mv = 1'b1; mp = ep; mi = rom_word(ep); ep = ep + 32'd4;
                    end
                end
                if (b) ep = {t[31:2], 2'b00};
                blk = b;
            end
            checks++;
            if (id_valid !== mv || id_pc !== mp || id_inst !== mi) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b pc=%h inst=%h, expected v=%b pc=%h inst=%h",
                         c, id_valid, id_pc, id_inst, mv, mp, mi);
            end
            checks++;
            if (rom_ce === 1'b1 && rom_addr[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL random_align[%0d]: got addr=%h, expected word aligned", c, rom_addr);
            end
        end
        rst = 1'b0; stall = 1'b0; branch = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        rst2 = 1'b1;
        repeat (2) tick();
        rst2 = 1'b0;
        #1;
        tick();
        exp_pc = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (id2_valid !== 1'b1 || id2_pc !== exp_pc || id2_inst !== rom_word(exp_pc)) begin
                errors++;
                $display("FAIL wrap[%0d]: got v=%b pc=%h inst=%h, expected v=1 pc=%h inst=%h",
                         i, id2_valid, id2_pc, id2_inst, exp_pc, rom_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_unaligned_branch_stall();
        test_reset_midstall();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
